// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
// Default operand width, FSM state encoding and operation select values.
package muldiv_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        FIX,
        DONE,
        HOLD
    } state_e;

endpackage

// File: rtl/muldiv_sign_fix.sv
// Conditional two's-complement negate: out = en ? -in : in.
// Purely combinational, no handshake.
module muldiv_sign_fix #(
    parameter int W = 32
) (
    input  logic         en,
    input  logic [W-1:0] in,
    output logic [W-1:0] out
);

    assign out = en ? (~in + W'(1)) : in;

endmodule

// File: rtl/iter_muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider on a start/done level handshake.
// Latency WIDTH+2 cycles from the accept cycle; start held past done parks in HOLD until released.
module iter_muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam int W2 = 2 * WIDTH;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [W2-1:0]    acc_q, acc_d;
    logic [WIDTH:0]   opnd_q, opnd_d;
    logic             op_q, op_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             dbz_pend_q, dbz_pend_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             dbz_q, dbz_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH:0]   abs_b;
    logic [WIDTH-1:0] acc_hi, acc_lo;
    logic [WIDTH:0]   mul_sum, div_trial;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [W2-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    assign a_neg = is_signed & opa[WIDTH-1];
    assign b_neg = is_signed & opb[WIDTH-1];

    // The dividend/multiplier magnitude is read as unsigned, so W bits hold 2^(W-1);
    // the other operand keeps W+1 bits to line up with the W+1-bit trial subtract.
    muldiv_sign_fix #(.W(WIDTH))   u_abs_a (.en(a_neg), .in(opa),          .out(abs_a));
    muldiv_sign_fix #(.W(WIDTH+1)) u_abs_b (.en(b_neg), .in({b_neg, opb}), .out(abs_b));

    assign acc_hi    = acc_q[W2-1:WIDTH];
    assign acc_lo    = acc_q[WIDTH-1:0];
    assign mul_sum   = {1'b0, acc_hi} + opnd_q;
    assign div_trial = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = (div_trial >= opnd_q);
    assign div_diff  = div_trial[WIDTH-1:0] - opnd_q[WIDTH-1:0];

    muldiv_sign_fix #(.W(W2))    u_fix_prod (.en(neg_res_q), .in(acc_q),  .out(prod_fix));
    muldiv_sign_fix #(.W(WIDTH)) u_fix_quo  (.en(neg_res_q), .in(acc_lo), .out(quo_fix));
    muldiv_sign_fix #(.W(WIDTH)) u_fix_rem  (.en(neg_rem_q), .in(acc_hi), .out(rem_fix));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        op_d       = op_q;
        neg_res_d  = neg_res_q;
        neg_rem_d  = neg_rem_q;
        dbz_pend_d = dbz_pend_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        dbz_d      = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = CALC;
                    cnt_d      = '0;
                    op_d       = op_div;
                    neg_res_d  = a_neg ^ b_neg;
                    neg_rem_d  = a_neg;
                    dbz_pend_d = (op_div == OP_DIV) && (opb == '0);
                    acc_d      = {{WIDTH{1'b0}}, abs_a};
                    opnd_d     = abs_b;
                end
            end
            CALC: begin
                if (op_q == OP_DIV) begin
                    acc_d = {(div_ge ? div_diff : div_trial[WIDTH-1:0]),
                             acc_lo[WIDTH-2:0], div_ge};
                end else if (acc_lo[0]) begin
                    acc_d = {mul_sum, acc_lo[WIDTH-1:1]};
                end else begin
                    acc_d = {1'b0, acc_q[W2-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (op_q == OP_MUL) begin
                    {hi_d, lo_d} = prod_fix;
                    dbz_d        = 1'b0;
                end else begin
                    // With a zero divisor the remainder path already rebuilds the original dividend.
                    hi_d  = rem_fix;
                    lo_d  = dbz_pend_q ? {WIDTH{1'b1}} : quo_fix;
                    dbz_d = dbz_pend_q;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = start ? HOLD : IDLE;
            end
            HOLD: begin
                if (!start) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            op_q       <= 1'b0;
            neg_res_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            dbz_pend_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            opnd_q     <= opnd_d;
            op_q       <= op_d;
            neg_res_q  <= neg_res_d;
            neg_rem_q  <= neg_rem_d;
            dbz_pend_q <= dbz_pend_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            dbz_q      <= dbz_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Bench for iter_muldiv_unit: directed spec vectors plus randomized ops against an arithmetic model.
module tb_iter_muldiv_unit;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    typedef struct {
        logic         div;
        logic         sgn;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         op_div;
    logic         is_signed;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;

    int n_cmp = 0;
    int n_err = 0;

    iter_muldiv_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op_div      (op_div),
        .is_signed   (is_signed),
        .opa         (opa),
        .opb         (opb),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Reference: {div_by_zero, hi, lo} from plain 64-bit arithmetic.
    function automatic logic [2*W:0] ref_model(input logic div, input logic sgn,
                                               input logic [W-1:0] a, input logic [W-1:0] b);
        longint       sa, sb;
        logic [2*W-1:0] p;
        logic [W-1:0] q, r;
        sa = sgn ? longint'($signed(a)) : longint'(a);
        sb = sgn ? longint'($signed(b)) : longint'(b);
        if (!div) begin
            p = 64'(sa * sb);
            return {1'b0, p};
        end
        if (b == '0) return {1'b1, a, {W{1'b1}}};
        q = W'(sa / sb);
        r = W'(sa % sb);
        return {1'b0, r, q};
    endfunction

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 1;
            2:       return '1;
            3:       return 32'h8000_0000;
            4:       return W'($urandom_range(0, 15));
            default: return $urandom();
        endcase
    endfunction

    // Called at a negedge; drives one op, scrambles inputs while busy, returns results seen with done.
    task automatic run_op(input logic div, input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] r_hi, output logic [W-1:0] r_lo, output logic r_dbz,
                          output int lat, output logic done_after);
        op_div = div; is_signed = sgn; opa = a; opb = b; start = 1'b1;
        lat = -1; r_hi = 'x; r_lo = 'x; r_dbz = 1'bx;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            op_div = 1'($urandom()); is_signed = 1'($urandom()); opa = $urandom(); opb = $urandom();
            if (done === 1'b1) begin
                lat = c; r_hi = hi; r_lo = lo; r_dbz = div_by_zero;
                break;
            end
        end
        start = 1'b0;
        @(negedge clk);
        done_after = done;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op_div = 1'b0; is_signed = 1'b0; opa = '0; opb = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if ({hi, lo} !== '0) begin n_err++; $display("FAIL reset_hilo: got %h_%h expected 0", hi, lo); end
        n_cmp++; if (div_by_zero !== 1'b0) begin n_err++; $display("FAIL reset_dbz: got %b expected 0", div_by_zero); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_mul();
        vec_t v[3];
        logic [W-1:0] r_hi, r_lo; logic r_dbz, d_after; int lat;
        v[0] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        v[1] = '{1'b0, 1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        v[2] = '{1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        for (int i = 0; i < 3; i++) begin
            run_op(v[i].div, v[i].sgn, v[i].a, v[i].b, r_hi, r_lo, r_dbz, lat, d_after);
            n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL mul_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
            n_cmp++; if (d_after !== 1'b0) begin n_err++; $display("FAIL mul_done_width[%0d]: done still %b one cycle later", i, d_after); end
            n_cmp++; if (r_hi !== v[i].hi) begin n_err++; $display("FAIL mul_hi[%0d]: got %h expected %h", i, r_hi, v[i].hi); end
            n_cmp++; if (r_lo !== v[i].lo) begin n_err++; $display("FAIL mul_lo[%0d]: got %h expected %h", i, r_lo, v[i].lo); end
        end
    endtask

    task automatic test_div();
        vec_t v[3];
        logic [W-1:0] r_hi, r_lo; logic r_dbz, d_after; int lat;
        v[0] = '{1'b1, 1'b0, 32'd100,        32'd7,        32'd2,        32'd14,       1'b0};
        v[1] = '{1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        v[2] = '{1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        for (int i = 0; i < 3; i++) begin
            run_op(v[i].div, v[i].sgn, v[i].a, v[i].b, r_hi, r_lo, r_dbz, lat, d_after);
            n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL div_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
            n_cmp++; if (r_hi !== v[i].hi) begin n_err++; $display("FAIL div_rem[%0d]: got %h expected %h", i, r_hi, v[i].hi); end
            n_cmp++; if (r_lo !== v[i].lo) begin n_err++; $display("FAIL div_quo[%0d]: got %h expected %h", i, r_lo, v[i].lo); end
            n_cmp++; if (r_dbz !== v[i].dbz) begin n_err++; $display("FAIL div_dbz[%0d]: got %b expected %b", i, r_dbz, v[i].dbz); end
        end
    endtask

    task automatic test_div_by_zero();
        vec_t v[3];
        logic [W-1:0] r_hi, r_lo; logic r_dbz, d_after; int lat;
        v[0] = '{1'b1, 1'b0, 32'd5,         32'd0, 32'd5,         32'hFFFF_FFFF, 1'b1};
        v[1] = '{1'b1, 1'b1, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1};
        v[2] = '{1'b1, 1'b0, 32'd100,       32'd7, 32'd2,         32'd14,        1'b0};
        for (int i = 0; i < 3; i++) begin
            run_op(v[i].div, v[i].sgn, v[i].a, v[i].b, r_hi, r_lo, r_dbz, lat, d_after);
            n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL dbz_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
            n_cmp++; if (r_hi !== v[i].hi) begin n_err++; $display("FAIL dbz_hi[%0d]: got %h expected %h", i, r_hi, v[i].hi); end
            n_cmp++; if (r_lo !== v[i].lo) begin n_err++; $display("FAIL dbz_lo[%0d]: got %h expected %h", i, r_lo, v[i].lo); end
            n_cmp++; if (r_dbz !== v[i].dbz) begin n_err++; $display("FAIL dbz_flag[%0d]: got %b expected %b", i, r_dbz, v[i].dbz); end
            n_cmp++; if (div_by_zero !== v[i].dbz) begin n_err++; $display("FAIL dbz_held[%0d]: got %b expected %b", i, div_by_zero, v[i].dbz); end
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] r_hi, r_lo; logic r_dbz, d_after, saw_done, saw_idle; int lat;
        op_div = 1'b0; is_signed = 1'b0; opa = 32'd3; opb = 32'd5; start = 1'b1;
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin lat = c; break; end
        end
        n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL hold_first_latency: got %0d expected %0d", lat, LAT); end
        saw_done = 1'b0; saw_idle = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
            if (busy !== 1'b1) saw_idle = 1'b1;
        end
        n_cmp++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL hold_no_redone: got done=1 expected none"); end
        n_cmp++; if (saw_idle !== 1'b0) begin n_err++; $display("FAIL hold_busy: got busy=0 expected 1 throughout"); end
        start = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL hold_release: got busy=%b expected 0", busy); end
        run_op(1'b0, 1'b0, 32'd6, 32'd7, r_hi, r_lo, r_dbz, lat, d_after);
        n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL hold_next_latency: got %0d expected %0d", lat, LAT); end
        n_cmp++; if ({r_hi, r_lo} !== 64'd42) begin n_err++; $display("FAIL hold_next_result: got %h_%h expected 0_2a", r_hi, r_lo); end
    endtask

    task automatic test_back_to_back();
        logic [2*W:0] prev, expv, got;
        logic [W-1:0] r_hi, r_lo, a, b; logic r_dbz, d_after, dv, sg; int lat;
        run_op(1'b0, 1'b0, 32'd12, 32'd12, r_hi, r_lo, r_dbz, lat, d_after);
        n_cmp++; if (r_lo !== 32'd144) begin n_err++; $display("FAIL b2b_seed: got %h expected 90", r_lo); end
        prev = ref_model(1'b0, 1'b0, 32'd12, 32'd12);
        for (int i = 0; i < 6; i++) begin
            dv = 1'($urandom()); sg = 1'($urandom()); a = pick_operand(); b = pick_operand();
            expv = ref_model(dv, sg, a, b);
            op_div = dv; is_signed = sg; opa = a; opb = b; start = 1'b1;
            @(negedge clk);
            got = {div_by_zero, hi, lo};
            n_cmp++; if (got !== prev) begin n_err++; $display("FAIL b2b_hold[%0d]: got %h expected %h", i, got, prev); end
            lat = -1;
            for (int c = 2; c <= 100; c++) begin
                @(negedge clk);
                if (done === 1'b1) begin lat = c; break; end
            end
            got = {div_by_zero, hi, lo};
            start = 1'b0;
            n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL b2b_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
            n_cmp++; if (got !== expv) begin n_err++; $display("FAIL b2b_result[%0d] div=%b sgn=%b a=%h b=%h: got %h expected %h", i, dv, sg, a, b, got, expv); end
            prev = expv;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] r_hi, r_lo; logic r_dbz, d_after, saw_done; int lat;
        run_op(1'b0, 1'b0, 32'd7, 32'd9, r_hi, r_lo, r_dbz, lat, d_after);
        n_cmp++; if (r_lo !== 32'd63) begin n_err++; $display("FAIL rstmid_pre: got %h expected 3f", r_lo); end
        op_div = 1'b0; is_signed = 1'b0; opa = '1; opb = '1; start = 1'b1;
        repeat (11) @(negedge clk);
        rst = 1'b1; start = 1'b0;
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rstmid_done: got %b expected 0", done); end
        n_cmp++; if ({hi, lo} !== '0) begin n_err++; $display("FAIL rstmid_hilo: got %h_%h expected 0", hi, lo); end
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0) saw_done = 1'b1;
        end
        n_cmp++; if (saw_done !== 1'b0) begin n_err++; $display("FAIL rstmid_stray_done: got done=1 expected none"); end
        run_op(1'b1, 1'b0, 32'd9, 32'd4, r_hi, r_lo, r_dbz, lat, d_after);
        n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL rstmid_latency: got %0d expected %0d", lat, LAT); end
        n_cmp++; if ({r_hi, r_lo} !== {32'd1, 32'd2}) begin n_err++; $display("FAIL rstmid_result: got %h_%h expected 1_2", r_hi, r_lo); end
    endtask

    task automatic test_random(input int n);
        logic [2*W:0] expv;
        logic [W-1:0] r_hi, r_lo, a, b; logic r_dbz, d_after, dv, sg; int lat;
        for (int i = 0; i < n; i++) begin
            dv = 1'($urandom()); sg = 1'($urandom()); a = pick_operand(); b = pick_operand();
            expv = ref_model(dv, sg, a, b);
            run_op(dv, sg, a, b, r_hi, r_lo, r_dbz, lat, d_after);
            n_cmp++; if (lat !== LAT) begin n_err++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", i, lat, LAT); end
            n_cmp++; if (d_after !== 1'b0) begin n_err++; $display("FAIL rnd_done_width[%0d]: done still %b", i, d_after); end
            n_cmp++; if ({r_dbz, r_hi, r_lo} !== expv) begin
                n_err++;
                $display("FAIL rnd_result[%0d] div=%b sgn=%b a=%h b=%h: got %b_%h_%h expected %h",
                         i, dv, sg, a, b, r_dbz, r_hi, r_lo, expv);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_div_by_zero();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_random(60);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
